ran_seq_player: RTL and testbench

Upstream stage of the Simon Says one-hot LED decoder. It builds the game's random step sequence with a free-running LFSR and stores each step as a 4-bit index. On request it plays the stored sequence back one step at a time. Its idx_out/idx_en pair drives the decoder's 12-bit index input and enable directly.

---
 rtl/ran_seq_player.sv | 159 +++++++++++++++
 tb/tb_ran_seq_player.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ran_seq_player.sv
// ran_seq_player
// Builds a random Simon Says step sequence from a free-running 12-bit LFSR and
// plays it back one step at a time into the one-hot LED decoder.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   seed_load  pulse: load LFSR from seed (zero seed selects DEF_SEED)
//   seed       12-bit LFSR seed
//   extend     pulse: append one random step (IDLE only, blocked when full)
//   play       pulse: play back the stored sequence (IDLE only)
//   clear      pulse: empty the sequence (IDLE only)
//   idx_out    current step index {8'b0, step}, zero while idx_en is low
//   idx_en     high while a step is presented
//   busy       high during playback
//   done       one-cycle pulse when playback ends
//   seq_len    number of stored steps
//   full       seq_len == MAX_LEN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting commands (clear > extend > play)
// ON    | presenting mem[ptr] with idx_en high for ON_CYCLES cycles
// OFF   | gap with idx_en low for OFF_CYCLES cycles, then next step or end
module ran_seq_player #(
  parameter int          MAX_LEN    = 32,
  parameter int          ON_CYCLES  = 8,
  parameter int          OFF_CYCLES = 4,
  parameter logic [11:0] DEF_SEED   = 12'hACE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [11:0]               seed,
  input  logic                      extend,
  input  logic                      play,
  input  logic                      clear,
  output logic [11:0]               idx_out,
  output logic                      idx_en,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(MAX_LEN):0]  seq_len,
  output logic                      full
);

  localparam int PW   = $clog2(MAX_LEN);
  localparam int LW   = PW + 1;
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  logic [1:0]    state;
  logic [11:0]   lfsr;
  logic          fb;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [TW-1:0] timer;
  logic [3:0]    mem [MAX_LEN];
  logic          do_write;
  logic          more_steps;

  assign fb         = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];
  assign ptr_nxt    = ptr + PW'(1);
  assign more_steps = ({1'b0, ptr} + LW'(1)) < seq_len;
  assign do_write   = (state == IDLE) && !clear && extend && !full;

  // LFSR runs in every state; seed_load overrides the shift for that edge.
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= DEF_SEED;
    else if (seed_load)
      lfsr <= (seed == 12'd0) ? DEF_SEED : seed;
    else
      lfsr <= {lfsr[10:0], fb};
  end

  // Captures the pre-update LFSR nibble.
  always_ff @(posedge clk) begin
    if (!rst && do_write)
      mem[seq_len[PW-1:0]] <= lfsr[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      timer   <= '0;
      idx_out <= '0;
      idx_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seq_len <= '0;
      full    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            seq_len <= '0;
            full    <= 1'b0;
          end else if (extend) begin
            if (!full) begin
              seq_len <= seq_len + LW'(1);
              full    <= (seq_len == LW'(MAX_LEN - 1));
            end
          end else if (play) begin
            if (seq_len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= ON;
              busy    <= 1'b1;
              ptr     <= '0;
              timer   <= TW'(ON_CYCLES - 1);
              idx_en  <= 1'b1;
              idx_out <= {8'b0, mem[0]};
            end
          end
        end
        ON: begin
          if (timer == '0) begin
            state   <= OFF;
            timer   <= TW'(OFF_CYCLES - 1);
            idx_en  <= 1'b0;
            idx_out <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        OFF: begin
          if (timer == '0) begin
            if (more_steps) begin
              state   <= ON;
              ptr     <= ptr_nxt;
              timer   <= TW'(ON_CYCLES - 1);
              idx_en  <= 1'b1;
              idx_out <= {8'b0, mem[ptr_nxt]};
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          idx_en  <= 1'b0;
          idx_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ran_seq_player.sv
module tb_ran_seq_player;

  localparam int MAX_LEN = 32;
  localparam int ONC     = 2;
  localparam int OFFC    = 1;

  typedef struct packed {
    logic [11:0] idx;
    logic        dn;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        seed_load;
  logic [11:0] seed;
  logic        extend;
  logic        play;
  logic        clear;
  logic [11:0] idx_out;
  logic        idx_en;
  logic        busy;
  logic        done;
  logic [5:0]  seq_len;
  logic        full;

  int   checks;
  int   errors;
  int   busy_cnt;
  exp_t q[$];

  ran_seq_player #(
    .MAX_LEN(MAX_LEN), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .DEF_SEED(12'hACE)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .extend(extend), .play(play), .clear(clear),
    .idx_out(idx_out), .idx_en(idx_en), .busy(busy), .done(done),
    .seq_len(seq_len), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a step or done.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (idx_en || done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: idx_out=%h idx_en=%b done=%b, expected no output",
                 idx_out, idx_en, done);
      end else begin
        e = q.pop_front();
        if ({idx_en, idx_out, done} !== {~e.dn, e.idx, e.dn}) begin
          errors++;
          $display("FAIL playback_out: idx_en=%b idx_out=%h done=%b, expected idx_en=%b idx_out=%h done=%b",
                   idx_en, idx_out, done, ~e.dn, e.idx, e.dn);
        end
      end
    end
    if (!idx_en) begin
      checks++;
      if (idx_out !== 12'h000) begin
        errors++;
        $display("FAIL idx_out_gap: got %h, expected 000", idx_out);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic play_seq(input int n, input logic [3:0] s0, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [3:0] s3, input bit inject);
    logic [3:0] st [4];
    int w;
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < ONC; c++)
        q.push_back('{idx: {8'b0, st[k]}, dn: 1'b0});
    q.push_back('{idx: 12'h000, dn: 1'b1});
    busy_cnt = 0;
    play = 1'b1;
    cyc();
    play = 1'b0;
    if (inject) begin
      cyc();
      cyc();
      extend = 1'b1; clear = 1'b1; play = 1'b1;
      cyc();
      extend = 1'b0; clear = 1'b0; play = 1'b0;
    end
    w = 0;
    while (q.size() != 0 && w < 200) begin
      cyc();
      w++;
    end
    chk("play_drained", q.size(), 0);
    chk("busy_cycles", busy_cnt, n * (ONC + OFFC));
    chk("busy_after", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("seq_len_frozen", seq_len, n);
  endtask

  initial begin
    checks = 0; errors = 0; busy_cnt = 0;
    rst = 1'b1; seed_load = 1'b0; seed = 12'h000;
    extend = 1'b0; play = 1'b0; clear = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state held through idle cycles
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_idx_en", idx_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_seq_len", seq_len, 0);
      chk("rst_idx_out", idx_out, 0);
      chk("rst_full", full, 0);
    end

    // Seed 001 then four extends: steps 1,2,4,8
    seed = 12'h001; seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    extend = 1'b1;
    repeat (4) cyc();
    extend = 1'b0;
    chk("seq_len_4", seq_len, 4);
    play_seq(4, 4'h1, 4'h2, 4'h4, 4'h8, 1'b0);

    // Play with empty sequence
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clear_len", seq_len, 0);
    play_seq(0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Saturation at MAX_LEN
    extend = 1'b1;
    repeat (MAX_LEN + 2) cyc();
    extend = 1'b0;
    chk("sat_len", seq_len, MAX_LEN);
    chk("sat_full", full, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_len", seq_len, 0);
    chk("clr_full", full, 0);

    // Command priority
    extend = 1'b1;
    repeat (3) cyc();
    extend = 1'b0;
    chk("len_3", seq_len, 3);
    clear = 1'b1; extend = 1'b1; play = 1'b1;
    cyc();
    clear = 1'b0; extend = 1'b0; play = 1'b0;
    chk("prio_clear_len", seq_len, 0);
    repeat (3) cyc();
    chk("prio_clear_busy", busy, 0);
    extend = 1'b1; play = 1'b1;
    cyc();
    extend = 1'b0; play = 1'b0;
    chk("prio_extend_len", seq_len, 1);
    repeat (3) cyc();
    chk("prio_extend_busy", busy, 0);
    chk("prio_extend_en", idx_en, 0);

    // Zero seed -> DEF_SEED 0xACE: steps E, D, A
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    seed = 12'h000; seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    extend = 1'b1;
    repeat (3) cyc();
    extend = 1'b0;
    chk("seq_len_3", seq_len, 3);
    // Commands during playback are ignored
    play_seq(3, 4'hE, 4'hD, 4'hA, 4'h0, 1'b1);

    // Reset mid-ON
    q.push_back('{idx: 12'h00E, dn: 1'b0});
    play = 1'b1;
    cyc();
    play = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_idx_en", idx_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_seq_len", seq_len, 0);
    chk("midrst_idx_out", idx_out, 0);
    chk("midrst_q", q.size(), 0);
    q.delete();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
